// File: rtl/cntr_mon_pkg.sv
// Shared types and constants for the limit-counter done monitor.
// Holds the readout FSM encoding, statistic select codes and default width.
package cntr_mon_pkg;

    localparam int NBYTES_DEF = 2;

    localparam logic SEL_EVT = 1'b0;
    localparam logic SEL_PER = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/cntr_done_monitor_if.sv
// Byte readout stream between the done monitor and its downstream consumer.
// A byte moves on any rising edge where out_valid && out_ready; while out_ready is low,
// the master holds out_valid and out_data unchanged, and out_valid never drops before the transfer.
interface cntr_done_monitor_if;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/cntr_mon_ser.sv
// Snapshot serializer: captures a statistic in IDLE and streams it LSB-first
// as NBYTES bytes over the valid/ready readout stream.
module cntr_mon_ser
    import cntr_mon_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic [8*NBYTES-1:0]   snap_in,
    cntr_done_monitor_if.master   rd_bus,
    output state_e                state
);

    localparam int CNT_W = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [CNT_W-1:0] snap;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            snap  <= '0;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_req) begin
                        snap  <= snap_in;
                        idx   <= '0;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (rd_bus.out_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_IDLE;
                        end else begin
                            // Next byte is always presented from the low lane.
                            snap <= snap >> 8;
                            idx  <= idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rd_bus.out_valid = (state == ST_SEND);
    assign rd_bus.out_data  = snap[7:0];

endmodule

// File: rtl/cntr_done_monitor.sv
// Monitor for the limit counter: wrap-event count, wrap period, sticky overflow,
// registered PWM compare, and a byte readout of either statistic.
module cntr_done_monitor
    import cntr_mon_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          cnt_q,
    input  logic                cnt_done,
    input  logic [7:0]          duty,
    input  logic                clr,
    input  logic                rd_req,
    input  logic                rd_sel,
    cntr_done_monitor_if.master rd_bus,
    output logic                busy,
    output logic                pwm,
    output logic                overflow
);

    localparam int CNT_W = 8 * NBYTES;
    localparam logic [CNT_W-1:0] MAX_V = '1;

    logic [CNT_W-1:0] evt_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] last_period;
    logic [CNT_W-1:0] snap_in;
    state_e           state;

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_cnt     <= '0;
            period_cnt  <= '0;
            last_period <= '0;
            overflow    <= 1'b0;
            pwm         <= 1'b0;
        end else begin
            pwm <= (cnt_q < duty);
            if (clr) begin
                evt_cnt     <= '0;
                period_cnt  <= '0;
                last_period <= '0;
                overflow    <= 1'b0;
            end else if (cnt_done) begin
                evt_cnt     <= (evt_cnt == MAX_V) ? MAX_V : evt_cnt + 1'b1;
                last_period <= (period_cnt == MAX_V) ? MAX_V : period_cnt + 1'b1;
                period_cnt  <= '0;
                // Overflow flags the edge on which the count lands on (or stays at) max.
                if (evt_cnt >= MAX_V - 1'b1) begin
                    overflow <= 1'b1;
                end
            end else begin
                period_cnt <= (period_cnt == MAX_V) ? MAX_V : period_cnt + 1'b1;
                if (period_cnt >= MAX_V - 1'b1) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Snapshot takes the pre-edge values; a same-cycle done/clr only moves the live registers.
    assign snap_in = (rd_sel == SEL_PER) ? last_period : evt_cnt;

    cntr_mon_ser #(.NBYTES(NBYTES)) u_ser (
        .clk     (clk),
        .rst     (rst),
        .rd_req  (rd_req),
        .snap_in (snap_in),
        .rd_bus  (rd_bus),
        .state   (state)
    );

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_cntr_done_monitor.sv
// Randomized and directed bench for cntr_done_monitor with a cycle-level
// reference model and an expected-byte queue checked by a separate monitor.
module tb_cntr_done_monitor;

  localparam int NB   = 2;
  localparam int MAXV = (1 << (8 * NB)) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cnt_q = '0;
  logic       cnt_done = 1'b0;
  logic [7:0] duty = '0;
  logic       clr = 1'b0;
  logic       rd_req = 1'b0;
  logic       rd_sel = 1'b0;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       pwm;
  logic       overflow;

  cntr_done_monitor_if bus ();
  assign bus.out_ready = out_ready;

  cntr_done_monitor #(.NBYTES(NB)) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_q    (cnt_q),
    .cnt_done (cnt_done),
    .duty     (duty),
    .clr      (clr),
    .rd_req   (rd_req),
    .rd_sel   (rd_sel),
    .rd_bus   (bus),
    .busy     (busy),
    .pwm      (pwm),
    .overflow (overflow)
  );

  // clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // reference model: statistics as plain saturating integers, readout as bytes left
  int         evt_m = 0, per_m = 0, last_m = 0, rem = 0;
  bit         ovf_m = 0, pwm_m = 0;
  logic [7:0] exp_q[$];

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      evt_m = 0; per_m = 0; last_m = 0; ovf_m = 0; pwm_m = 0; rem = 0;
      exp_q.delete();
    end else begin
      pwm_m = (int'(cnt_q) < int'(duty));
      if (rem == 0 && rd_req) begin
        int v;
        v = rd_sel ? last_m : evt_m;
        for (int i = 0; i < NB; i++) exp_q.push_back(8'((v >> (8 * i)) & 8'hFF));
        rem = NB;
      end else if (rem > 0 && out_ready) begin
        rem--;
      end
      if (clr) begin
        evt_m = 0; per_m = 0; last_m = 0; ovf_m = 0;
      end else if (cnt_done) begin
        evt_m  = sat(evt_m + 1);
        last_m = sat(per_m + 1);
        per_m  = 0;
        if (evt_m == MAXV) ovf_m = 1;
      end else begin
        per_m = sat(per_m + 1);
        if (per_m == MAXV) ovf_m = 1;
      end
    end
  end

  // monitor / scoreboard
  int          mon_idx = 0;
  int          n_reads = 0;
  logic [15:0] rd_acc = '0;
  logic [15:0] last_rd = '0;
  bit          hold_v = 0;
  logic [7:0]  hold_d = '0;

  always @(negedge clk) begin
    check("busy", int'(busy), int'(rem > 0));
    check("out_valid", int'(bus.out_valid), int'(rem > 0));
    check("pwm", int'(pwm), int'(pwm_m));
    check("overflow", int'(overflow), int'(ovf_m));
    if (rst) begin
      mon_idx = 0;
      rd_acc  = '0;
    end else if (bus.out_valid) begin
      if (hold_v) check("hold_data", int'(bus.out_data), int'(hold_d));
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", int'(bus.out_data), -1);
        end else begin
          check("byte", int'(bus.out_data), int'(exp_q.pop_front()));
        end
        rd_acc = rd_acc | (16'(bus.out_data) << (8 * mon_idx));
        mon_idx++;
        if (mon_idx == NB) begin
          last_rd = rd_acc;
          rd_acc  = '0;
          mon_idx = 0;
          n_reads++;
        end
      end
    end
    hold_v = bus.out_valid && !out_ready && !rst;
    hold_d = bus.out_data;
  end

  // driver: behavioural upstream limit counter plus pulse inputs
  int limit = 255;
  int cval  = 0;

  task automatic cyc();
    cnt_q    = 8'(cval);
    cnt_done = (cval == limit);
    @(posedge clk);
    #1;
    cval   = (cval >= limit) ? 0 : cval + 1;
    rd_req = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic set_limit(input int l);
    limit = l;
    cval  = 0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (rem != 0 && k < 100) begin
      cyc();
      k++;
    end
    if (k == 100) check({name, "_timeout"}, rem, 0);
  endtask

  task automatic read(input bit sel);
    wait_idle("read_pre");
    rd_sel = sel;
    rd_req = 1'b1;
    cyc();
    wait_idle("read");
  endtask

  initial begin
    int q;
    int nr;

    // reset
    rst = 1'b1;
    cycles(2);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_data", int'(bus.out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pwm", int'(pwm), 0);
    check("rst_ovf", int'(overflow), 0);
    rst = 1'b0;

    // limit=4, three wraps, read period
    set_limit(4);
    clr = 1'b1;
    cyc();
    cycles(14);
    read(1'b1);
    check("period_l4", int'(last_rd), 16'h0005);
    check("busy_after_l4", int'(busy), 0);

    // limit=0 for 10 cycles, read event count and period
    set_limit(0);
    clr = 1'b1;
    cyc();
    cycles(10);
    set_limit(200);
    read(1'b0);
    check("evt_10", int'(last_rd), 16'h000A);
    read(1'b1);
    check("period_l0", int'(last_rd), 16'h0001);

    // snapshot on the same edge as a done pulse
    set_limit(0);
    clr = 1'b1;
    cyc();
    cycles(7);
    rd_sel = 1'b0;
    rd_req = 1'b1;
    cyc();
    set_limit(200);
    wait_idle("snap_done");
    check("snap_pre_edge", int'(last_rd), 16'h0007);
    read(1'b0);
    check("live_after_snap", int'(last_rd), 16'h0008);

    // event count saturation and clear
    set_limit(0);
    clr = 1'b1;
    cyc();
    cycles(MAXV - 1);
    check("ovf_before_max", int'(overflow), 0);
    cycles(3);
    set_limit(200);
    check("ovf_at_max", int'(overflow), 1);
    read(1'b0);
    check("evt_sat", int'(last_rd), 16'hFFFF);
    clr = 1'b1;
    cyc();
    check("ovf_clr", int'(overflow), 0);
    read(1'b0);
    check("evt_clr", int'(last_rd), 16'h0000);

    // stalled readout, extra rd_req while sending
    set_limit(4);
    cycles(12);
    nr = n_reads;
    out_ready = 1'b0;
    rd_sel = 1'b1;
    rd_req = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) rd_req = 1'b1;
      cyc();
      check("stall_valid", int'(bus.out_valid), 1);
      check("stall_lsb", int'(bus.out_data), 8'h05);
    end
    out_ready = 1'b1;
    wait_idle("stall");
    check("stall_read", int'(last_rd), 16'h0005);
    cycles(4);
    check("stall_one_read", n_reads - nr, 1);
    check("stall_busy", int'(busy), 0);

    // PWM compare
    duty = 8'd3;
    set_limit(5);
    for (int i = 0; i < 12; i++) begin
      q = cval;
      cyc();
      check("pwm_d3", int'(pwm), int'(q < 3));
    end
    duty = 8'd0;
    set_limit(255);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("pwm_d0", int'(pwm), 0);
    end
    duty = 8'd255;
    cval = 252;
    for (int i = 0; i < 6; i++) begin
      q = cval;
      cyc();
      check("pwm_d255", int'(pwm), int'(q != 255));
    end

    // reset in the middle of a readout
    out_ready = 1'b0;
    rd_req = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    check("rst_send_valid", int'(bus.out_valid), 0);
    check("rst_send_busy", int'(busy), 0);
    rst = 1'b0;
    out_ready = 1'b1;

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst = 1'b0;
      if ($urandom_range(0, 49) == 0) set_limit($urandom_range(0, 20));
      if ($urandom_range(0, 19) == 0) duty = 8'($urandom_range(0, 255));
      rd_req    = ($urandom_range(0, 3) == 0);
      rd_sel    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst = 1'b0;
    out_ready = 1'b1;
    wait_idle("drain");
    cycles(2);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
